// File: rtl/multicycle_alu.sv
// Clocked ALU arithmetic path: single-cycle ADC/SUB, iterative shift-add MUL/MUH
// and restoring DIV/MOD on signed operands, behind a start/busy/done handshake.
package instruction_set_pkg;
  typedef enum logic [2:0] {
    OP_ADC, OP_SUB, OP_MUL, OP_MUH, OP_DIV, OP_MOD, OP_AND, OP_NOP
  } operation_e;

  typedef struct packed {
    logic irq_enable;
    logic overflow;
    logic parity;
    logic negative;
    logic zero;
    logic carry;
  } flags_t;
endpackage

module multicycle_alu
  import instruction_set_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  operation_e            operation,
  input  flags_t                in_flags,
  input  logic [data_width-1:0] in_src,
  input  logic [data_width-1:0] in_dest,
  output logic [data_width-1:0] out_dest,
  output flags_t                out_flags,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            state_dbg
);
  localparam int W  = data_width;
  localparam int CW = $clog2(data_width) + 1;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  // Handshake: start is taken on a rising edge only while busy=0; done is a
  // one-cycle pulse and out_dest/out_flags hold until the next result lands.
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE} state_e;

  state_e           state, state_nxt;
  operation_e       op_q;
  flags_t           flags_q;
  logic             multi, sa, sb;
  logic [W-1:0]     dest_q, b_mag, mplier, rem, quo;
  logic [2*W-1:0]   mcand_sh, prod;
  logic [CW-1:0]    cnt;
  logic             accept, is_multi_op, last_step;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  assign is_multi_op = operation inside {OP_MUL, OP_MUH, OP_DIV, OP_MOD};
  assign accept      = start && (state == S_IDLE || (state == S_DONE && !multi));
  assign last_step   = (cnt == CW'(W - 1));
  assign busy        = (state != S_IDLE) && !(state == S_DONE && !multi);
  assign done        = (state == S_DONE);
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // The first engine step runs in LOAD, so LOAD plus ITER covers W steps.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: state_nxt = accept ? (is_multi_op ? S_LOAD : S_DONE) : S_IDLE;
      S_LOAD:         state_nxt = S_ITER;
      S_ITER:         if (last_step) state_nxt = S_FIX;
      S_FIX:          state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  logic [W:0]   sum_w, diff_w;
  logic [W-1:0] quick_res;
  flags_t       quick_flags;

  always_comb begin
    sum_w       = {1'b0, in_src} + {1'b0, in_dest} + {{W{1'b0}}, in_flags.carry};
    diff_w      = {1'b0, in_dest} - {1'b0, in_src} - {{W{1'b0}}, in_flags.carry};
    quick_res   = '0;
    quick_flags = in_flags;
    case (operation)
      OP_ADC: begin
        quick_res            = sum_w[W-1:0];
        quick_flags.carry    = sum_w[W];
        quick_flags.overflow = (in_src[W-1] == in_dest[W-1]) && (sum_w[W-1] != in_dest[W-1]);
      end
      OP_SUB: begin
        quick_res            = diff_w[W-1:0];
        quick_flags.carry    = diff_w[W];
        quick_flags.overflow = (in_src[W-1] != in_dest[W-1]) && (diff_w[W-1] != in_dest[W-1]);
      end
      default: ;
    endcase
    if (operation == OP_ADC || operation == OP_SUB) begin
      quick_flags.zero     = (quick_res == '0);
      quick_flags.negative = quick_res[W-1];
      quick_flags.parity   = ~^quick_res;
    end
  end

  logic [W:0]     rem_t;
  logic [W-1:0]   rem_sub;
  logic           rem_ge;

  always_comb begin
    rem_t   = {rem, quo[W-1]};
    rem_ge  = (rem_t >= {1'b0, b_mag});
    rem_sub = rem_t[W-1:0] - b_mag;
  end

  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s, rem_s, fix_res;
  logic           fix_v, div0, div_ovf;
  flags_t         fix_flags;

  always_comb begin
    prod_s  = (sa ^ sb) ? -prod : prod;
    quo_s   = (sa ^ sb) ? -quo : quo;
    rem_s   = sa ? -rem : rem;
    div0    = (b_mag == '0);
    div_ovf = (dest_q == MIN_VAL) && sb && (b_mag == W'(1));
    fix_res = '0;
    fix_v   = 1'b0;
    case (op_q)
      OP_MUL: begin
        fix_res = prod_s[W-1:0];
        fix_v   = (prod_s[2*W-1:W] != {W{prod_s[W-1]}});
      end
      OP_MUH: fix_res = prod_s[2*W-1:W];
      OP_DIV: begin
        fix_res = div0 ? {W{1'b1}} : quo_s;
        fix_v   = div0 || div_ovf;
      end
      OP_MOD: begin
        fix_res = div0 ? dest_q : rem_s;
        fix_v   = div0;
      end
      default: ;
    endcase
    fix_flags          = flags_q;
    fix_flags.overflow = fix_v;
    fix_flags.zero     = (fix_res == '0);
    fix_flags.negative = fix_res[W-1];
    fix_flags.parity   = ~^fix_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_ADC;
      flags_q   <= '0;
      multi     <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dest_q    <= '0;
      b_mag     <= '0;
      mplier    <= '0;
      mcand_sh  <= '0;
      prod      <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      out_dest  <= '0;
      out_flags <= '0;
    end else begin
      if (accept) begin
        op_q     <= operation;
        flags_q  <= in_flags;
        multi    <= is_multi_op;
        sa       <= in_dest[W-1];
        sb       <= in_src[W-1];
        dest_q   <= in_dest;
        b_mag    <= mag(in_src);
        mplier   <= mag(in_src);
        mcand_sh <= {{W{1'b0}}, mag(in_dest)};
        prod     <= '0;
        rem      <= '0;
        quo      <= mag(in_dest);
        cnt      <= '0;
        if (!is_multi_op) begin
          out_dest  <= quick_res;
          out_flags <= quick_flags;
        end
      end
      // Both engines step together on unsigned magnitudes; FIX picks the result.
      if (state == S_LOAD || state == S_ITER) begin
        if (mplier[0]) prod <= prod + mcand_sh;
        mcand_sh <= mcand_sh << 1;
        mplier   <= mplier >> 1;
        rem      <= rem_ge ? rem_sub : rem_t[W-1:0];
        quo      <= {quo[W-2:0], rem_ge};
        cnt      <= cnt + CW'(1);
      end
      if (state == S_FIX) begin
        out_dest  <= fix_res;
        out_flags <= fix_flags;
      end
    end
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// Randomised and directed bench for multicycle_alu against a plain-arithmetic
// reference model; results flow through an expected-value queue.
module tb_multicycle_alu;
  import instruction_set_pkg::*;

  localparam int W         = 16;
  localparam int MULTI_LAT = W + 2;
  localparam int BUDGET    = 40;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  operation_e   operation = OP_NOP;
  flags_t       in_flags = '0;
  logic [W-1:0] in_src = '0;
  logic [W-1:0] in_dest = '0;
  logic [W-1:0] out_dest;
  flags_t       out_flags;
  logic         busy, done;
  logic [2:0]   state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  flags_t       expf_q[$];

  multicycle_alu #(.data_width(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
    .in_flags(in_flags), .in_src(in_src), .in_dest(in_dest),
    .out_dest(out_dest), .out_flags(out_flags), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: signed integer arithmetic straight from the opcode rules.
  task automatic model(input operation_e op, input flags_t fi, input logic [W-1:0] src,
                       input logic [W-1:0] dest, output logic [W-1:0] res, output flags_t fo);
    int s, d, t;
    s   = int'($signed(src));
    d   = int'($signed(dest));
    t   = 0;
    fo  = fi;
    res = '0;
    case (op)
      OP_ADC: begin
        t = int'(src) + int'(dest) + int'(fi.carry);
        res = t[15:0];
        fo.carry = t[16];
        fo.overflow = (src[15] == dest[15]) && (res[15] != dest[15]);
      end
      OP_SUB: begin
        t = int'(dest) - int'(src) - int'(fi.carry);
        res = t[15:0];
        fo.carry = (t < 0);
        fo.overflow = (src[15] != dest[15]) && (res[15] != dest[15]);
      end
      OP_MUL: begin
        t = d * s;
        res = t[15:0];
        fo.overflow = (t > 32767) || (t < -32768);
      end
      OP_MUH: begin
        t = d * s;
        res = t[31:16];
        fo.overflow = 1'b0;
      end
      OP_DIV: begin
        if (s == 0) begin res = 16'hFFFF; fo.overflow = 1'b1; end
        else if (d == -32768 && s == -1) begin res = 16'h8000; fo.overflow = 1'b1; end
        else begin t = d / s; res = t[15:0]; fo.overflow = 1'b0; end
      end
      OP_MOD: begin
        if (s == 0) begin res = dest; fo.overflow = 1'b1; end
        else begin t = d % s; res = t[15:0]; fo.overflow = 1'b0; end
      end
      default: ;
    endcase
    if (op inside {OP_ADC, OP_SUB, OP_MUL, OP_MUH, OP_DIV, OP_MOD}) begin
      fo.zero     = (res == 16'h0);
      fo.negative = res[15];
      fo.parity   = ($countones(res) % 2 == 0);
    end
  endtask

  // Drives one operation and checks busy, latency, result and the done pulse.
  task automatic run_op(input operation_e op, input flags_t fi, input logic [W-1:0] src,
                        input logic [W-1:0] dest, output logic [W-1:0] res_o, output flags_t flg_o);
    logic [W-1:0] r;
    flags_t f;
    bit multi;
    int k, guard;
    guard = 0;
    while (busy && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    model(op, fi, src, dest, r, f);
    exp_q.push_back(r);
    expf_q.push_back(f);
    multi = op inside {OP_MUL, OP_MUH, OP_DIV, OP_MOD};
    operation = op; in_flags = fi; in_src = src; in_dest = dest; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_src = 16'($urandom);
    in_dest = 16'($urandom);
    in_flags = flags_t'(6'($urandom));
    k = 0;
    while (k < BUDGET) begin
      @(negedge clk);
      k++;
      check("busy", 32'(busy), 32'(multi));
      if (done) break;
    end
    if (!done) begin
      check("done_timeout", 32'(done), 32'(1));
      void'(exp_q.pop_front());
      void'(expf_q.pop_front());
    end else begin
      check("latency", 32'(k), multi ? 32'(MULTI_LAT) : 32'(1));
      check("result", 32'(out_dest), 32'(exp_q.pop_front()));
      check("flags", 32'(out_flags), 32'(expf_q.pop_front()));
    end
    res_o = out_dest;
    flg_o = out_flags;
    if (multi) begin
      @(negedge clk);
      check("done_pulse", 32'(done), 32'(0));
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      case ($urandom_range(0, 5))
        0: v = 16'h0000;
        1: v = 16'h0001;
        2: v = 16'hFFFF;
        3: v = 16'h8000;
        4: v = 16'h7FFF;
        default: v = 16'h0002;
      endcase
    end
    return v;
  endfunction

  initial begin
    logic [W-1:0] r, held;
    flags_t f, fz, fr;
    int ndone, k;
    fz = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dest", 32'(out_dest), 32'(0));
    check("rst_flags", 32'(out_flags), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_ADC, fz, 16'h0001, 16'h7FFF, r, f);
    check("adc_ovf_res", 32'(r), 32'h8000);
    check("adc_ovf_vnczp", {27'd0, f.overflow, f.negative, f.carry, f.zero, f.parity}, 32'b11000);
    run_op(OP_SUB, fz, 16'd5, 16'd5, r, f);
    check("sub_zero_res", 32'(r), 32'h0);
    check("sub_zero_zpvc", {28'd0, f.zero, f.parity, f.overflow, f.carry}, 32'b1100);
    run_op(OP_MUL, fz, 16'd5, 16'hFFFD, r, f);
    check("mul_res", 32'(r), 32'hFFF1);
    check("mul_nv", {30'd0, f.negative, f.overflow}, 32'b10);
    run_op(OP_MUH, fz, 16'd5, 16'hFFFD, r, f);
    check("muh_res", 32'(r), 32'hFFFF);
    run_op(OP_DIV, fz, 16'd2, 16'hFFF9, r, f);
    check("div_res", 32'(r), 32'hFFFD);
    run_op(OP_MOD, fz, 16'd2, 16'hFFF9, r, f);
    check("mod_res", 32'(r), 32'hFFFF);
    run_op(OP_DIV, fz, 16'd0, 16'd1234, r, f);
    check("div0_res", 32'(r), 32'hFFFF);
    check("div0_v", 32'(f.overflow), 32'(1));
    run_op(OP_MOD, fz, 16'd0, 16'd1234, r, f);
    check("mod0_res", 32'(r), 32'd1234);
    run_op(OP_DIV, fz, 16'hFFFF, 16'h8000, r, f);
    check("div_min_res", 32'(r), 32'h8000);
    check("div_min_v", 32'(f.overflow), 32'(1));
    run_op(OP_MOD, fz, 16'hFFFF, 16'h8000, r, f);
    check("mod_min_res", 32'(r), 32'h0);
    check("mod_min_v", 32'(f.overflow), 32'(0));
    fr = flags_t'(6'b101011);
    run_op(OP_AND, fr, 16'h00FF, 16'h0F0F, r, f);
    check("other_res", 32'(r), 32'h0);
    check("other_flags", 32'(f), 32'(fr));
    run_op(OP_MUL, fz, 16'h0100, 16'h0100, r, f);
    check("mul_ovf_v", 32'(f.overflow), 32'(1));

    // Random mix; consecutive single-cycle ops also exercise start during done.
    for (int i = 0; i < 80; i++) begin
      run_op(operation_e'($urandom_range(0, 7)), flags_t'(6'($urandom)), pick(), pick(), r, f);
    end

    // A held start during a multiply must be ignored.
    while (busy) @(negedge clk);
    operation = OP_MUL; in_flags = fz; in_src = 16'd7; in_dest = 16'hFFF7; start = 1'b1;
    @(posedge clk);
    #1;
    operation = OP_ADC; in_src = 16'd1; in_dest = 16'd2;
    ndone = 0;
    k = 0;
    while (k < BUDGET && ndone == 0) begin
      @(negedge clk);
      k++;
      if (done) ndone++;
    end
    start = 1'b0;
    check("hs_latency", 32'(k), 32'(MULTI_LAT));
    check("hs_mul_res", 32'(out_dest), 32'hFFC1);
    held = out_dest;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("hs_done_count", 32'(ndone), 32'(1));
    check("hs_hold", 32'(out_dest), 32'(held));

    // Reset during the divide's iterations aborts it without a done.
    operation = OP_DIV; in_src = 16'd3; in_dest = 16'd100; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_dest", 32'(out_dest), 32'(0));
    check("abort_flags", 32'(out_flags), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
